// File: rtl/shift_sequencer.sv
// Bit-serial shifter: one shared 2N:1 mux tree produces one result bit per cycle,
// steered by a bit-index counter, behind valid/ready handshakes on both sides.

module shift_mux #(
    parameter int W = 64
) (
    input  logic [W-1:0]         v,
    input  logic [$clog2(W)-1:0] sel,
    output logic                 out
);
    always_comb begin
        out = v[sel];
    end
endmodule

module shift_sequencer #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [N-1:0]         a,
    input  logic [$clog2(N)-1:0] shamt,
    input  logic [1:0]           op,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [N-1:0]         y
);
    localparam int SW   = $clog2(N);
    localparam int SELW = $clog2(2 * N);

    localparam logic [SELW-1:0] N_SEL    = SELW'(N);
    localparam logic [SW-1:0]   IDX_LAST = SW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } op_t;

    state_t          state, state_n;
    op_t             op_q;
    logic [N-1:0]    a_q;
    logic [SW-1:0]   sh_q;
    logic [SW-1:0]   idx;
    logic [2*N-1:0]  v;
    logic [SELW-1:0] sel;
    logic            mux_out;

    always_comb begin
        state_n = state;
        i_ready = 1'b0;
        o_valid = 1'b0;
        case (state)
            IDLE: begin
                i_ready = 1'b1;
                if (i_valid) state_n = RUN;
            end
            RUN: begin
                if (idx == IDX_LAST) state_n = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (o_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // SLL reads a_q from the upper half so that idx < sh_q lands on the zero half
    always_comb begin
        v   = {{N{1'b0}}, a_q};
        sel = {1'b0, idx};
        case (op_q)
            OP_SLL: begin
                v   = {a_q, {N{1'b0}}};
                sel = N_SEL + {1'b0, idx} - {1'b0, sh_q};
            end
            OP_SRL: begin
                sel = {1'b0, idx} + {1'b0, sh_q};
            end
            OP_SRA: begin
                v   = {{N{a_q[N-1]}}, a_q};
                sel = {1'b0, idx} + {1'b0, sh_q};
            end
            default: begin
                sel = {1'b0, idx};
            end
        endcase
    end

    shift_mux #(.W(2 * N)) u_mux (
        .v   (v),
        .sel (sel),
        .out (mux_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            y     <= '0;
            a_q   <= '0;
            sh_q  <= '0;
            op_q  <= OP_SLL;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_q  <= a;
                        sh_q <= shamt;
                        op_q <= op_t'(op);
                        idx  <= '0;
                        y    <= '0;
                    end
                end
                RUN: begin
                    y[idx] <= mux_out;
                    if (idx != IDX_LAST) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
